// File: rtl/phase_tracker.sv
// Tracks the fetch/decode/exec/wrbk strobe sequence and counts retired cycles.
// Define PHASE_CHECK_EN to enable protocol checking (err/err_code, idle timeout).
module phase_tracker #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_clk,
  input  logic             decode_clk,
  input  logic             exec_clk,
  input  logic             wrbk_clk,
  input  logic             clr_err,
  output logic             sync_ok,
  output logic [1:0]       phase,
  output logic             retire_pulse,
  output logic [CNT_W-1:0] retire_count,
  output logic             err,
  output logic [1:0]       err_code
);

  // state     | meaning
  // SYNC_WAIT | unlocked, waiting for a lone fetch strobe
  // EXP_D     | locked, fetch seen, expecting decode
  // EXP_E     | locked, expecting exec
  // EXP_W     | locked, expecting wrbk (accepting it retires a cycle)
  // EXP_F     | locked, expecting fetch
  typedef enum logic [2:0] {SYNC_WAIT, EXP_D, EXP_E, EXP_W, EXP_F} state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;

  state_t             state_q;
  state_t             state_adv;
  logic [3:0]         strobe;
  logic [3:0]         exp_strobe;
  logic [1:0]         phase_adv;
  logic               accept;
  logic               sync_ok_q;
  logic               retire_pulse_q;
  logic [1:0]         phase_q;
  logic [CNT_W-1:0]   retire_count_q;
  logic [CNT_W-1:0]   retire_count_d;

  assign strobe         = {wrbk_clk, exec_clk, decode_clk, fetch_clk};
  assign retire_count_d = retire_count_q + CNT_W'(1);
  assign accept         = (strobe == exp_strobe);

  // SYNC_WAIT shares the accept path with EXP_F: a lone fetch locks the tracker.
  always_comb begin
    exp_strobe = 4'b0001;
    state_adv  = EXP_D;
    phase_adv  = 2'b00;
    case (state_q)
      EXP_D: begin exp_strobe = 4'b0010; state_adv = EXP_E; phase_adv = 2'b01; end
      EXP_E: begin exp_strobe = 4'b0100; state_adv = EXP_W; phase_adv = 2'b10; end
      EXP_W: begin exp_strobe = 4'b1000; state_adv = EXP_F; phase_adv = 2'b11; end
      default: ;
    endcase
  end

`ifdef PHASE_CHECK_EN
  localparam logic [1:0] ERR_ORDER   = 2'b01;
  localparam logic [1:0] ERR_MULTI   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic       err_q;
  logic [1:0] err_code_q;
  logic [1:0] viol_code;
  logic [7:0] idle_q;
  logic [7:0] idle_d;
  logic       multi_hot;

  assign idle_d    = idle_q + 8'd1;
  assign multi_hot = (strobe & (strobe - 4'd1)) != 4'd0;

  always_comb begin
    viol_code = ERR_NONE;
    if (state_q != SYNC_WAIT && !accept) begin
      if (strobe == 4'd0) begin
        if (idle_d == 8'(TIMEOUT)) viol_code = ERR_TIMEOUT;
      end else if (multi_hot) begin
        viol_code = ERR_MULTI;
      end else begin
        viol_code = ERR_ORDER;
      end
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err            = 1'b0;
  assign err_code       = ERR_NONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SYNC_WAIT;
      sync_ok_q      <= 1'b0;
      phase_q        <= 2'b00;
      retire_pulse_q <= 1'b0;
      retire_count_q <= '0;
`ifdef PHASE_CHECK_EN
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
      idle_q         <= '0;
`endif
    end else begin
      retire_pulse_q <= 1'b0;
      if (accept) begin
        state_q   <= state_adv;
        phase_q   <= phase_adv;
        sync_ok_q <= 1'b1;
        if (state_q == EXP_W) begin
          retire_count_q <= retire_count_d;
          retire_pulse_q <= 1'b1;
        end
      end
`ifdef PHASE_CHECK_EN
      if (strobe == 4'd0 && state_q != SYNC_WAIT) idle_q <= idle_d;
      else                                         idle_q <= '0;
      if (clr_err) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      // A violation overrides a same-cycle clear and records its own code.
      if (viol_code != ERR_NONE) begin
        state_q   <= SYNC_WAIT;
        sync_ok_q <= 1'b0;
        idle_q    <= '0;
        err_q     <= 1'b1;
        if (!err_q || clr_err) err_code_q <= viol_code;
      end
`endif
    end
  end

  assign sync_ok      = sync_ok_q;
  assign phase        = phase_q;
  assign retire_pulse = retire_pulse_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_phase_tracker.sv
// Bench for phase_tracker: per-cycle compare against a sequence-level model,
// plus literal checkpoints. Follows PHASE_CHECK_EN like the design.
module tb_phase_tracker;
  localparam int TIMEOUT = 8;
`ifdef PHASE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [3:0] F = 4'b0001, D = 4'b0010, E = 4'b0100, W = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_clk = 1'b0, decode_clk = 1'b0, exec_clk = 1'b0, wrbk_clk = 1'b0;
  logic        clr_err = 1'b0;

  logic        sync_ok, retire_pulse, err;
  logic [1:0]  phase, err_code;
  logic [15:0] retire_count;
  logic        sync_ok4, retire_pulse4, err4;
  logic [1:0]  phase4, err_code4;
  logic [3:0]  retire_count4;

  int errors = 0;
  int checks = 0;

  phase_tracker #(.CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fetch_clk(fetch_clk), .decode_clk(decode_clk),
    .exec_clk(exec_clk), .wrbk_clk(wrbk_clk), .clr_err(clr_err),
    .sync_ok(sync_ok), .phase(phase), .retire_pulse(retire_pulse),
    .retire_count(retire_count), .err(err), .err_code(err_code)
  );

  phase_tracker #(.CNT_W(4), .TIMEOUT(TIMEOUT)) dut4 (
    .clk(clk), .rst(rst), .fetch_clk(fetch_clk), .decode_clk(decode_clk),
    .exec_clk(exec_clk), .wrbk_clk(wrbk_clk), .clr_err(clr_err),
    .sync_ok(sync_ok4), .phase(phase4), .retire_pulse(retire_pulse4),
    .retire_count(retire_count4), .err(err4), .err_code(err_code4)
  );

  always #5 clk = ~clk;

  // Model: locked flag plus index of last accepted phase; next expected strobe is
  // simply the one-hot of (phase+1) mod 4.
  bit m_locked = 0;
  int m_phase  = 0;
  int m_count  = 0;
  bit m_pulse  = 0;
  bit m_err    = 0;
  int m_code   = 0;
  int m_idle   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] s, input logic c);
    int code;
    code = 0;
    if (r) begin
      m_locked = 0; m_phase = 0; m_pulse = 0; m_count = 0;
      m_err = 0; m_code = 0; m_idle = 0;
    end else begin
      m_pulse = 0;
      if (!m_locked) begin
        if (s == 4'b0001) begin m_locked = 1; m_phase = 0; m_idle = 0; end
      end else if (s == (4'b0001 << ((m_phase + 1) % 4))) begin
        m_phase = (m_phase + 1) % 4;
        m_idle  = 0;
        if (m_phase == 3) begin m_count++; m_pulse = 1; end
      end else if (CHECK_EN) begin
        if (s == 4'b0000) begin
          m_idle++;
          if (m_idle == TIMEOUT) code = 3;
        end else if ($countones(s) > 1) code = 2;
        else code = 1;
      end
      if (CHECK_EN && c) begin m_err = 0; m_code = 0; end
      if (code != 0) begin
        if (!m_err) m_code = code;
        m_err = 1; m_locked = 0; m_idle = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(rst, {wrbk_clk, exec_clk, decode_clk, fetch_clk}, clr_err);
    #1;
    chk("sync_ok", 32'(sync_ok), 32'(m_locked));
    chk("phase", 32'(phase), 32'(m_phase));
    chk("retire_pulse", 32'(retire_pulse), 32'(m_pulse));
    chk("retire_count", 32'(retire_count), 32'(m_count % 65536));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("sync_ok4", 32'(sync_ok4), 32'(m_locked));
    chk("retire_pulse4", 32'(retire_pulse4), 32'(m_pulse));
    chk("retire_count4", 32'(retire_count4), 32'(m_count % 16));
    chk("err_code4", 32'(err_code4), 32'(m_code));
  end

  task automatic step(input logic [3:0] s, input logic c = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    {wrbk_clk, exec_clk, decode_clk, fetch_clk} = s;
    clr_err = c;
    rst     = r;
    @(posedge clk);
    #2;
  endtask

  task automatic instr();
    step(F); step(D); step(E); step(W);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("rst sync_ok", 32'(sync_ok), 0);
    chk("rst retire_count", 32'(retire_count), 0);
    chk("rst err", 32'(err), 0);

    // three clean instruction cycles
    step(F);
    chk("lock sync_ok", 32'(sync_ok), 1);
    chk("lock phase", 32'(phase), 0);
    step(D); step(E); step(W);
    chk("first retire pulse", 32'(retire_pulse), 1);
    chk("first retire count", 32'(retire_count), 1);
    instr(); instr();
    chk("three retires", 32'(retire_count), 3);

    // wrbk while expecting exec
    step(F); step(D); step(W);
`ifdef PHASE_CHECK_EN
    chk("ooo err", 32'(err), 1);
    chk("ooo err_code", 32'(err_code), 1);
    chk("ooo sync_ok", 32'(sync_ok), 0);
    step(F);
    chk("relock sync_ok", 32'(sync_ok), 1);
`else
    chk("nocheck err", 32'(err), 0);
    chk("nocheck sync_ok", 32'(sync_ok), 1);
    chk("nocheck phase held", 32'(phase), 1);
    step(F);
`endif
    chk("count kept after ooo", 32'(retire_count), 3);
    step(D); step(E); step(W, 1'b1);
    chk("count after resume", 32'(retire_count), 4);
    chk("err cleared", 32'(err), 0);

    // multi-hot, later violation, clear
    step(F); step(4'b0011);
`ifdef PHASE_CHECK_EN
    chk("multi err_code", 32'(err_code), 2);
`endif
    step(F); step(4'b0110);
`ifdef PHASE_CHECK_EN
    chk("sticky err_code", 32'(err_code), 2);
`endif
    step(4'b0000, 1'b1);
    chk("clr err", 32'(err), 0);
    chk("clr err_code", 32'(err_code), 0);
    step(F); step(W); step(F); step(4'b0101, 1'b1);
`ifdef PHASE_CHECK_EN
    chk("clr vs violation", 32'(err_code), 2);
`endif

    // idle handling
    step(4'b0000, 1'b1);
    step(F);
    repeat (7) step(4'b0000);
    step(D);
    chk("7 idle no err", 32'(err), 0);
    chk("7 idle phase", 32'(phase), 1);
    step(E); step(W); step(F);
    chk("count 5", 32'(retire_count), 5);
    repeat (7) step(4'b0000);
    chk("pre-timeout sync", 32'(sync_ok), 1);
    step(4'b0000);
`ifdef PHASE_CHECK_EN
    chk("timeout err_code", 32'(err_code), 3);
    chk("timeout sync", 32'(sync_ok), 0);
`else
    chk("no timeout sync", 32'(sync_ok), 1);
`endif

    // wrap of the 4-bit counter
    step(F);
    repeat (10) begin step(D); step(E); step(W); step(F); end
    chk("count4 at 15", 32'(retire_count4), 15);
    step(D); step(E); step(W);
    chk("count4 wrap", 32'(retire_count4), 0);
    chk("pulse4 on wrap", 32'(retire_pulse4), 1);
    chk("count16 no wrap", 32'(retire_count), 16);

    // reset on the wrbk edge
    step(F); step(D); step(E); step(W, 1'b0, 1'b1);
    chk("rst wrbk count", 32'(retire_count), 0);
    chk("rst wrbk pulse", 32'(retire_pulse), 0);
    chk("rst wrbk sync", 32'(sync_ok), 0);
    step(4'b0000);
    chk("no late pulse", 32'(retire_pulse), 0);
    instr();
    chk("count after rst", 32'(retire_count), 1);

    // repeated strobe
    step(F); step(D); step(D);
`ifdef PHASE_CHECK_EN
    chk("repeat err_code", 32'(err_code), 1);
`else
    chk("repeat held phase", 32'(phase), 1);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
